// File: rtl/premuat3_ctrl.sv
// premuat3_ctrl -- row sequencer for the transform permutation datapath.
//
// Accepts one block of N = 4 << transize rows (4, 8, 16 or 32) from
// upstream, drives the datapath output-register load strobe and tracks the
// row held in that register until downstream takes it. Block configuration
// (size, inverse flag) is latched at start and held for the whole block.
//
// Ports
//   clk          rising-edge clock for all state
//   rst          synchronous active-high reset
//   i_start      block start request (acted on only in IDLE)
//   i_transize   size code 0..3 = 4x4..32x32
//   i_inverse    inverse-transform flag
//   i_flush      abort current block
//   i_valid      upstream row valid
//   o_ready      upstream row accept
//   o_transize   latched size to datapath
//   o_inverse    latched inverse flag to datapath
//   o_load       datapath output-register load (i_valid & o_ready)
//   o_valid      output-register row valid to downstream
//   i_ready      downstream accept
//   o_row        index of row held in output register
//   o_last       held row is the final row of the block
//   o_busy       state is not IDLE
//   o_done       one-cycle block-complete pulse
//   o_err        one-cycle pulse on i_start while busy
//
// state | meaning
// IDLE  | waiting for i_start, nothing in flight
// RUN   | accepting rows 0..N-1 from upstream
// DRAIN | all rows accepted, waiting for last row handshake downstream
module premuat3_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [1:0] i_transize,
  input  logic       i_inverse,
  input  logic       i_flush,
  input  logic       i_valid,
  output logic       o_ready,
  output logic [1:0] o_transize,
  output logic       o_inverse,
  output logic       o_load,
  output logic       o_valid,
  input  logic       i_ready,
  output logic [4:0] o_row,
  output logic       o_last,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t     state;
  logic [4:0] cnt;
  logic [4:0] last_idx;
  logic       handshake;
  logic       last_accept;

  always_comb begin
    last_idx = 5'd3;
    case (o_transize)
      2'd0:    last_idx = 5'd3;
      2'd1:    last_idx = 5'd7;
      2'd2:    last_idx = 5'd15;
      default: last_idx = 5'd31;
    endcase
  end

  assign o_ready     = (state == RUN) && (!o_valid || i_ready);
  assign o_load      = i_valid && o_ready;
  assign o_busy      = (state != IDLE);
  assign handshake   = o_valid && i_ready;
  assign last_accept = (cnt == last_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 5'd0;
      o_transize <= 2'd0;
      o_inverse  <= 1'b0;
      o_valid    <= 1'b0;
      o_row      <= 5'd0;
      o_last     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      if (i_flush) begin
        // Abort wins over everything except reset; o_row is left stale
        // because o_valid=0 marks it as meaningless.
        state   <= IDLE;
        cnt     <= 5'd0;
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // A start coinciding with o_done is dropped so the previous
            // block's completion is always seen before a new one begins.
            if (i_start && !o_done) begin
              o_transize <= i_transize;
              o_inverse  <= i_inverse;
              cnt        <= 5'd0;
              state      <= RUN;
            end
          end
          RUN: begin
            if (i_start) o_err <= 1'b1;
            if (o_load) begin
              o_valid <= 1'b1;
              o_row   <= cnt;
              o_last  <= last_accept;
              if (last_accept) begin
                // Counter parks at N-1 rather than stepping past the block.
                state <= DRAIN;
              end else begin
                cnt <= cnt + 5'd1;
              end
            end else if (handshake) begin
              o_valid <= 1'b0;
              o_last  <= 1'b0;
            end
          end
          DRAIN: begin
            if (i_start) o_err <= 1'b1;
            if (handshake) begin
              o_valid <= 1'b0;
              o_last  <= 1'b0;
              if (o_last) begin
                state  <= IDLE;
                o_done <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_premuat3_ctrl.sv
module tb_premuat3_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_start;
  logic [1:0] i_transize;
  logic       i_inverse;
  logic       i_flush;
  logic       i_valid;
  logic       o_ready;
  logic [1:0] o_transize;
  logic       o_inverse;
  logic       o_load;
  logic       o_valid;
  logic       i_ready;
  logic [4:0] o_row;
  logic       o_last;
  logic       o_busy;
  logic       o_done;
  logic       o_err;

  int errors = 0;
  int checks = 0;

  premuat3_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_transize (i_transize),
    .i_inverse  (i_inverse),
    .i_flush    (i_flush),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_transize (o_transize),
    .o_inverse  (o_inverse),
    .o_load     (o_load),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_row      (o_row),
    .o_last     (o_last),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_block(input logic [1:0] ts, input logic inv);
    i_transize = ts;
    i_inverse  = inv;
    i_start    = 1'b1;
    tick();
    i_start    = 1'b0;
  endtask

  logic       held_v;
  logic [4:0] held_r;
  logic       held_l;
  logic       hs;
  int         exp_next;
  int         dones;

  initial begin
    rst = 1'b1; i_start = 1'b0; i_transize = 2'd3; i_inverse = 1'b1;
    i_flush = 1'b0; i_valid = 1'b1; i_ready = 1'b1;
    tick(); tick();
    // reset values with rst still high
    chk("rst_busy",  32'(o_busy), 0);
    chk("rst_ready", 32'(o_ready), 0);
    chk("rst_load",  32'(o_load), 0);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_row",   32'(o_row), 0);
    chk("rst_ts",    32'(o_transize), 0);
    chk("rst_inv",   32'(o_inverse), 0);
    chk("rst_done",  32'(o_done), 0);
    rst = 1'b0;
    tick();

    // 4x4 block, inverse, continuous flow
    start_block(2'd0, 1'b1);
    chk("t1_busy", 32'(o_busy), 1);
    chk("t1_ts",   32'(o_transize), 0);
    chk("t1_inv",  32'(o_inverse), 1);
    chk("t1_load", 32'(o_load), 1);
    for (int r = 0; r < 4; r++) begin
      tick();
      chk("t1_valid", 32'(o_valid), 1);
      chk("t1_row",   32'(o_row), 32'(r));
      chk("t1_last",  32'(o_last), 32'(r == 3));
      chk("t1_done",  32'(o_done), 0);
    end
    chk("t1_ready_drain", 32'(o_ready), 0);
    tick();
    chk("t1_done_pulse", 32'(o_done), 1);
    chk("t1_valid_off",  32'(o_valid), 0);
    chk("t1_idle",       32'(o_busy), 0);
    tick();
    chk("t1_done_once", 32'(o_done), 0);
    chk("t1_inv_hold",  32'(o_inverse), 1);

    // 32x32 block with downstream ready toggling
    start_block(2'd3, 1'b0);
    exp_next = 0;
    dones = 0;
    for (int c = 0; c < 200 && dones == 0; c++) begin
      i_ready = c[0];
      #1;
      held_v = o_valid; held_r = o_row; held_l = o_last;
      hs = o_valid & i_ready;
      if (hs) begin
        chk("t2_order", 32'(o_row), 32'(exp_next));
        chk("t2_last",  32'(o_last), 32'(exp_next == 31));
        exp_next++;
      end
      tick();
      if (held_v && !hs) begin
        chk("t2_hold_valid", 32'(o_valid), 1);
        chk("t2_hold_row",   32'(o_row), 32'(held_r));
        chk("t2_hold_last",  32'(o_last), 32'(held_l));
      end
      if (o_done) dones++;
    end
    chk("t2_rows", 32'(exp_next), 32);
    chk("t2_done", 32'(dones), 1);
    tick();
    chk("t2_done_once", 32'(o_done), 0);
    chk("t2_ts", 32'(o_transize), 3);

    // 8x8 block with stray start at row 3
    i_ready = 1'b1;
    start_block(2'd1, 1'b0);
    for (int r = 0; r < 8; r++) begin
      tick();
      i_start = 1'b0;
      chk("t3_row", 32'(o_row), 32'(r));
      chk("t3_err", 32'(o_err), 32'(r == 4));
      chk("t3_ts",  32'(o_transize), 1);
      chk("t3_inv", 32'(o_inverse), 0);
      if (r == 3) begin
        i_start = 1'b1; i_transize = 2'd2; i_inverse = 1'b1;
      end
    end
    chk("t3_last", 32'(o_last), 1);
    tick();
    chk("t3_done", 32'(o_done), 1);
    tick();

    // 16x16 block flushed at row 7, then a 4x4 block
    start_block(2'd2, 1'b0);
    for (int r = 0; r < 8; r++) begin
      tick();
      chk("t4_row", 32'(o_row), 32'(r));
    end
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    chk("t4_busy",  32'(o_busy), 0);
    chk("t4_valid", 32'(o_valid), 0);
    chk("t4_last",  32'(o_last), 0);
    chk("t4_done",  32'(o_done), 0);
    tick();
    chk("t4_done2", 32'(o_done), 0);
    start_block(2'd0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      tick();
      chk("t4b_row",  32'(o_row), 32'(r));
      chk("t4b_last", 32'(o_last), 32'(r == 3));
    end
    tick();
    chk("t4b_done", 32'(o_done), 1);

    // start in the o_done cycle is dropped silently
    i_start = 1'b1; i_transize = 2'd1; i_inverse = 1'b1;
    tick();
    i_start = 1'b0;
    chk("t6_err",  32'(o_err), 0);
    chk("t6_busy", 32'(o_busy), 0);
    chk("t6_ts",   32'(o_transize), 0);
    tick();
    chk("t6_still_idle", 32'(o_busy), 0);
    start_block(2'd1, 1'b1);
    chk("t6_started", 32'(o_busy), 1);
    chk("t6_ts2",     32'(o_transize), 1);

    // reset in DRAIN with a stalled last row
    for (int r = 0; r < 8; r++) begin
      tick();
      chk("t5_row", 32'(o_row), 32'(r));
    end
    i_ready = 1'b0;
    tick();
    chk("t5_hold_valid", 32'(o_valid), 1);
    chk("t5_hold_row",   32'(o_row), 7);
    chk("t5_hold_last",  32'(o_last), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_valid", 32'(o_valid), 0);
    chk("t5_row",   32'(o_row), 0);
    chk("t5_last",  32'(o_last), 0);
    chk("t5_done",  32'(o_done), 0);
    chk("t5_err",   32'(o_err), 0);
    chk("t5_ts",    32'(o_transize), 0);
    chk("t5_inv",   32'(o_inverse), 0);
    chk("t5_busy",  32'(o_busy), 0);
    chk("t5_ready", 32'(o_ready), 0);
    chk("t5_load",  32'(o_load), 0);
    tick();
    chk("t5_no_done", 32'(o_done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/premuat3_ctrl.md
PREMUAT3_CTRL -- requirements
Module: premuat3_ctrl

Interface
REQ-001 The block SHALL have no parameters; widths are fixed by the 4x4..32x32 transform sizes.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 i_start  input  1  block-start request, sampled only in IDLE.
REQ-005 i_transize  input  2  block size code: 0=4x4, 1=8x8, 2=16x16, 3=32x32.
REQ-006 i_inverse  input  1  inverse-transform flag for the block.
REQ-007 i_flush  input  1  abort of the current block.
REQ-008 i_valid  input  1  upstream row valid.
REQ-009 o_ready  output  1  upstream row accept.
REQ-010 o_transize  output  2  latched size, driven to the permutation datapath.
REQ-011 o_inverse  output  1  latched inverse flag, driven to the permutation datapath.
REQ-012 o_load  output  1  datapath output-register load strobe, equal to i_valid & o_ready.
REQ-013 o_valid  output  1  registered datapath row valid to downstream.
REQ-014 i_ready  input  1  downstream accept.
REQ-015 o_row  output  5  index of the row held in the output register.
REQ-016 o_last  output  1  high with o_valid when the held row is the final row of the block.
REQ-017 o_busy  output  1  high whenever the state is not IDLE.
REQ-018 o_done  output  1  one-cycle block-complete pulse.
REQ-019 o_err  output  1  one-cycle pulse when i_start arrives while busy.

Function
REQ-020 The block SHALL implement the states IDLE, RUN and DRAIN, encoded in 2 bits.
REQ-021 In IDLE, i_start=1 SHALL latch i_transize and i_inverse into o_transize and o_inverse, clear the accept counter and move to RUN on the next edge.
REQ-022 o_transize and o_inverse SHALL hold constant from that latch until the next accepted start.
REQ-023 The row count per block SHALL be N = 4 << i_transize, giving 4, 8, 16 or 32 rows.
REQ-024 o_ready SHALL equal (state==RUN) & (!o_valid | i_ready), so no row is accepted in IDLE, in DRAIN or in the start cycle.
REQ-025 On each accepted row (o_load=1):
  - o_valid SHALL be set on the next edge;
  - o_row SHALL take the accept-counter value;
  - the accept counter SHALL increment;
  - o_last SHALL be set when the counter value equals N-1.
REQ-026 Latency SHALL be exactly 1 cycle from o_load to o_valid.
REQ-027 Throughput SHALL be 1 row per cycle while i_ready=1.
REQ-028 While o_valid=1 and i_ready=0, o_valid, o_row and o_last SHALL hold unchanged.
REQ-029 o_valid SHALL clear after a downstream handshake (o_valid & i_ready) unless a new row is loaded in the same cycle.
REQ-030 Acceptance of row N-1 SHALL move the state RUN->DRAIN.
REQ-031 In DRAIN, the handshake of the row with o_last=1 SHALL return the state to IDLE and assert o_done on the next cycle, for one cycle.
REQ-032 i_start while busy SHALL be ignored for configuration and state and SHALL pulse o_err for one cycle.
REQ-033 i_start in the same cycle as o_done SHALL be ignored with no o_err; a new block starts at the earliest in the cycle after o_done.
REQ-034 i_flush=1 in any state SHALL, on the next edge:
  - force IDLE;
  - clear o_valid, o_last and the counter;
  - suppress o_done.
  i_flush SHALL take priority over i_start, o_load and the handshake.
REQ-035 The accept counter SHALL be 5 bits and SHALL never exceed N-1, so there is no wrap-around within a block.

Reset
REQ-036 rst=1 at a clock edge SHALL force IDLE and the counter to 0.
REQ-037 rst=1 at a clock edge SHALL force o_transize=0, o_inverse=0, o_valid=0, o_row=0, o_last=0, o_done=0 and o_err=0.
REQ-038 After reset, o_ready, o_load and o_busy SHALL be 0.
REQ-039 Reset mid-block SHALL discard the block with no o_done.
REQ-040 rst SHALL take priority over i_flush and all other inputs.

Verification
REQ-041 Start with transize=0, inverse=1, i_valid=1 and i_ready=1 held -> o_transize=0 and o_inverse=1 held; 4 consecutive o_valid cycles with o_row=0..3; o_last only on row 3; o_done 1 cycle later.
REQ-042 Start with transize=3 and i_ready toggling 1/0 each cycle -> 32 rows delivered in order 0..31; o_row is stable while i_ready=0; no row is lost or duplicated; o_done once.
REQ-043 Start with transize=1 and a second i_start at row 3 -> o_err pulses 1 cycle; o_transize stays 1; 8 rows still delivered.
REQ-044 Start with transize=2 and i_flush at row 7 -> IDLE next cycle; o_valid=0; no o_done; the next start with transize=0 yields rows 0..3.
REQ-045 rst asserted in DRAIN with o_valid=1 and i_ready=0 -> all outputs 0 next cycle; no o_done.
REQ-046 i_start asserted in the o_done cycle -> no o_err; the block starts only when i_start is reasserted.
